// File: rtl/queue_monitor.sv
// Queue occupancy monitor: edge-detected entry/exit photocells drive a saturating people counter
// with registered flags. Define WAIT_EST_EN to compile in the serial wait-time estimator.
module queue_monitor #(
  parameter int unsigned N      = 3,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned AF_LVL = DEPTH - 1,
  parameter int unsigned AE_LVL = 1,
  parameter int unsigned T_W    = 2,
  parameter int unsigned SVC_T  = 3,
  parameter int unsigned W_W    = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           front_sensor,
  input  logic           back_sensor,
  input  logic [T_W-1:0] Tcount,
  output logic [N-1:0]   Pcount,
  output logic           empty_flag,
  output logic           full_flag,
  output logic           almost_empty,
  output logic           almost_full,
  output logic           overflow_err,
  output logic           underflow_err,
  output logic [W_W-1:0] Wtime,
  output logic           wt_valid
);

  localparam logic [N-1:0] DepthVal = N'(DEPTH);

  logic         front_q, back_q;
  logic [N-1:0] pcount_d, pcount_q;
  logic         empty_d, empty_q, full_d, full_q;
  logic         ae_d, ae_q, af_d, af_q;
  logic         ovf_d, ovf_q, unf_d, unf_q;
  logic         ent, ext;

  always_comb begin
    ent      = front_sensor & ~front_q;
    ext      = back_sensor & ~back_q;
    pcount_d = pcount_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (ent && !ext) begin
      if (pcount_q < DepthVal) pcount_d = pcount_q + N'(1);
      else                     ovf_d    = 1'b1;
    end else if (ext && !ent) begin
      if (pcount_q != '0) pcount_d = pcount_q - N'(1);
      else                unf_d    = 1'b1;
    end else if (ent && ext && pcount_q == '0) begin
      // Empty queue: the exit cannot be honoured, but the entry still counts.
      pcount_d = pcount_q + N'(1);
      unf_d    = 1'b1;
    end
    empty_d = (pcount_d == '0);
    full_d  = (pcount_d == DepthVal);
    af_d    = (32'(pcount_d) >= AF_LVL);
    ae_d    = (32'(pcount_d) <= AE_LVL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q  <= 1'b0;
      back_q   <= 1'b0;
      pcount_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      front_q  <= front_sensor;
      back_q   <= back_sensor;
      pcount_q <= pcount_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign Pcount        = pcount_q;
  assign empty_flag    = empty_q;
  assign full_flag     = full_q;
  assign almost_empty  = ae_q;
  assign almost_full   = af_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef WAIT_EST_EN
  localparam int unsigned NumMax = SVC_T * ((1 << N) + (1 << T_W));
  localparam int unsigned NumW   = $clog2(NumMax + 1);
  localparam int unsigned WMax   = (1 << W_W) - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCalc = 2'd2;

  logic [1:0]      st_d, st_q;
  logic [NumW-1:0] rem_d, rem_q, quo_d, quo_q;
  logic [T_W-1:0]  den_d, den_q, tc_last_d, tc_last_q;
  logic [N-1:0]    pc_last_d, pc_last_q;
  logic [W_W-1:0]  wtime_d, wtime_q;
  logic            wt_valid_d, wt_valid_q;
  logic            chg;

  always_comb begin
    st_d       = st_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    den_d      = den_q;
    tc_last_d  = tc_last_q;
    pc_last_d  = pc_last_q;
    wtime_d    = wtime_q;
    wt_valid_d = wt_valid_q;
    // Inputs differ from the operands of the last division started.
    chg        = (pcount_q != pc_last_q) || (Tcount != tc_last_q);
    case (st_q)
      StLoad: begin
        pc_last_d = pcount_q;
        tc_last_d = Tcount;
        if (Tcount == '0) begin
          wtime_d    = '1;
          wt_valid_d = 1'b1;
          st_d       = StIdle;
        end else begin
          rem_d = NumW'(SVC_T) * (NumW'(pcount_q) + NumW'(Tcount) - NumW'(1));
          den_d = Tcount;
          quo_d = '0;
          st_d  = StCalc;
        end
      end
      StCalc: begin
        if (chg) begin
          st_d       = StLoad;
          wt_valid_d = 1'b0;
        end else if (rem_q < NumW'(den_q)) begin
          wtime_d    = (32'(quo_q) > WMax) ? '1 : W_W'(quo_q);
          wt_valid_d = 1'b1;
          st_d       = StIdle;
        end else begin
          rem_d = rem_q - NumW'(den_q);
          quo_d = quo_q + NumW'(1);
        end
      end
      default: begin
        if (chg) begin
          st_d       = StLoad;
          wt_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      tc_last_q  <= '0;
      pc_last_q  <= '0;
      wtime_q    <= '0;
      wt_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      den_q      <= den_d;
      tc_last_q  <= tc_last_d;
      pc_last_q  <= pc_last_d;
      wtime_q    <= wtime_d;
      wt_valid_q <= wt_valid_d;
    end
  end

  assign Wtime    = wtime_q;
  assign wt_valid = wt_valid_q;
`else
  logic unused_tcount;
  assign unused_tcount = ^Tcount;
  assign Wtime         = '0;
  assign wt_valid      = 1'b0;
`endif

endmodule
